// File: rtl/fft_corner_turn_buffer.sv
// Corner-turn buffer: captures an N x N frame row-major, replays it column-major.
// Single frame store, alternating FILL and DRAIN, AXI-Stream on both sides.
module fft_corner_turn_buffer #(
    parameter int N_LOG2 = 7,
    parameter int DW     = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] s_axis_tdata,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic          s_axis_tlast,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic          m_axis_tlast,
    output logic          frame_done,
    output logic          err_tlast_unexp,
    output logic          err_tlast_miss
);

    localparam int N     = 1 << N_LOG2;
    localparam int DEPTH = N * N;

    typedef enum logic {FILL, DRAIN} state_t;

    state_t state;

    logic [N_LOG2-1:0] wr_row, wr_col;
    logic [N_LOG2-1:0] rd_row, rd_col;
    logic              rd_all;

    logic [DW-1:0] mem [DEPTH];

    logic [DW-1:0] ram_q;
    logic          ram_vld, ram_last, ram_fin;
    logic [DW-1:0] skid_data;
    logic          skid_vld, skid_last, skid_fin;
    logic          out_fin;

    logic       in_beat, out_beat, wr_last, issue;
    logic [1:0] occ;

    assign in_beat  = s_axis_tvalid & s_axis_tready;
    assign out_beat = m_axis_tvalid & m_axis_tready;
    assign wr_last  = (&wr_row) && (&wr_col);

    // Beats held in the output pair plus the one in flight from the RAM.
    assign occ = 2'(m_axis_tvalid) + 2'(skid_vld) + 2'(ram_vld);

    // First read goes out on the very edge that enters DRAIN.
    assign issue = !rd_all
                && (occ <= 2'(out_beat) + 2'd1)
                && (state == DRAIN || (in_beat && wr_last));

    assign frame_done = out_beat & out_fin;

    always_ff @(posedge clk) begin
        if (in_beat)
            mem[{wr_row, wr_col}] <= s_axis_tdata;
        if (issue)
            ram_q <= mem[{rd_row, rd_col}];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= FILL;
            s_axis_tready   <= 1'b0;
            wr_row          <= '0;
            wr_col          <= '0;
            rd_row          <= '0;
            rd_col          <= '0;
            rd_all          <= 1'b0;
            ram_vld         <= 1'b0;
            ram_last        <= 1'b0;
            ram_fin         <= 1'b0;
            skid_data       <= '0;
            skid_vld        <= 1'b0;
            skid_last       <= 1'b0;
            skid_fin        <= 1'b0;
            m_axis_tdata    <= '0;
            m_axis_tvalid   <= 1'b0;
            m_axis_tlast    <= 1'b0;
            out_fin         <= 1'b0;
            err_tlast_unexp <= 1'b0;
            err_tlast_miss  <= 1'b0;
        end else begin
            err_tlast_unexp <= in_beat & s_axis_tlast & ~(&wr_col);
            err_tlast_miss  <= in_beat & ~s_axis_tlast & (&wr_col);

            ram_vld <= issue;
            if (issue) begin
                ram_last <= &rd_row;
                ram_fin  <= (&rd_row) && (&rd_col);
                rd_row   <= rd_row + 1'b1;
                if (&rd_row) begin
                    rd_col <= rd_col + 1'b1;
                    if (&rd_col)
                        rd_all <= 1'b1;
                end
            end

            if (out_beat) begin
                if (skid_vld) begin
                    m_axis_tdata <= skid_data;
                    m_axis_tlast <= skid_last;
                    out_fin      <= skid_fin;
                    skid_vld     <= ram_vld;
                    if (ram_vld) begin
                        skid_data <= ram_q;
                        skid_last <= ram_last;
                        skid_fin  <= ram_fin;
                    end
                end else begin
                    m_axis_tvalid <= ram_vld;
                    if (ram_vld) begin
                        m_axis_tdata <= ram_q;
                        m_axis_tlast <= ram_last;
                        out_fin      <= ram_fin;
                    end
                end
            end else if (ram_vld) begin
                if (!m_axis_tvalid) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= ram_q;
                    m_axis_tlast  <= ram_last;
                    out_fin       <= ram_fin;
                end else begin
                    skid_vld  <= 1'b1;
                    skid_data <= ram_q;
                    skid_last <= ram_last;
                    skid_fin  <= ram_fin;
                end
            end

            unique case (state)
                FILL: begin
                    s_axis_tready <= 1'b1;
                    if (in_beat) begin
                        wr_col <= wr_col + 1'b1;
                        if (&wr_col)
                            wr_row <= wr_row + 1'b1;
                        if (wr_last) begin
                            state         <= DRAIN;
                            s_axis_tready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (frame_done) begin
                        state         <= FILL;
                        s_axis_tready <= 1'b1;
                        rd_all        <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
